usb_pkt_builder: RTL and testbench

//  Reads a USB data payload of 128-bit words from the dual-port packet RAM via its read port B.

---
 rtl/usb_pkt_pkg.sv | 33 +++
 rtl/usb_crc16.sv | 23 ++
 rtl/usb_pkt_builder.sv | 218 +++++++++++++++++++++
 tb/tb_usb_pkt_builder.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkt_pkg.sv
// rtl/usb_pkt_pkg.sv - shared types, constants and CRC16 helper for the USB packet builder
package usb_pkt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PID,
        PAYLOAD,
        CRC_LO,
        CRC_HI
    } pkt_state_t;

    localparam logic [15:0] CRC16_INIT   = 16'hFFFF;
    localparam logic [15:0] CRC16_POLY_R = 16'hA001;

    localparam logic [3:0] DATA0 = 4'b0011;
    localparam logic [3:0] DATA1 = 4'b1011;
    localparam logic [3:0] DATA2 = 4'b0111;
    localparam logic [3:0] MDATA = 4'b1111;

    // Fold one byte into a reflected USB CRC16, LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i])
                c = (c >> 1) ^ CRC16_POLY_R;
            else
                c = c >> 1;
        end
        return c;
    endfunction

endpackage

// File: rtl/usb_crc16.sv
// rtl/usb_crc16.sv - byte-serial USB CRC16 register
module usb_crc16
    import usb_pkt_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  din,
    output logic [15:0] crc
);

    // Restart on init, otherwise fold in each enabled byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            crc <= CRC16_INIT;
        else if (init)
            crc <= CRC16_INIT;
        else if (en)
            crc <= crc16_byte(crc, din);
    end

endmodule

// File: rtl/usb_pkt_builder.sv
// rtl/usb_pkt_builder.sv - reads a payload from packet RAM and streams PID, payload and CRC16 bytes
module usb_pkt_builder
    import usb_pkt_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 128,
    parameter int MAX_WORDS = 64,
    parameter int CNT_W     = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        pid,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              tx_last
);

    localparam int BYTES = DATA_W / 8;
    localparam int SC_W  = $clog2(BYTES + 1);
    localparam logic [SC_W-1:0]  SC_FULL = SC_W'(BYTES);
    localparam logic [SC_W-1:0]  SC_LOAD = SC_W'(BYTES - 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

    pkt_state_t        state;
    logic [3:0]        pid_q;
    logic              has_payload;
    logic [CNT_W-1:0]  rd_left;
    logic [ADDR_W-1:0] next_addr;
    logic              rd_pending;
    logic [DATA_W-1:0] hold_data;
    logic              hold_valid;
    logic [DATA_W-1:0] sh_data;
    logic [SC_W-1:0]   sh_cnt;
    logic [15:0]       crc;
    logic [15:0]       crc_after;
    logic [15:0]       crc_final;

    logic       out_free;
    logic       tx_fire;
    logic       src_sh;
    logic       byte_avail;
    logic [7:0] next_byte;
    logic       payload_src;
    logic       pop;
    logic       reads_done;
    logic       issue_rd;
    logic       start_ok;
    logic       crc_en;

    assign out_free    = !tx_valid || tx_ready;
    assign tx_fire     = tx_valid && tx_ready;
    assign src_sh      = (sh_cnt != '0);
    assign byte_avail  = src_sh || hold_valid;
    assign next_byte   = src_sh ? sh_data[7:0] : hold_data[7:0];
    // The first payload byte is fetched in the same cycle the PID byte leaves.
    assign payload_src = (state == PAYLOAD) || (state == PID && tx_fire && has_payload);
    assign pop         = out_free && byte_avail && payload_src;
    assign reads_done  = (rd_left == '0) && !ram_en && !rd_pending && !hold_valid && !src_sh;
    assign issue_rd    = (state == PID || state == PAYLOAD) && (rd_left != '0)
                         && !ram_en && !rd_pending && !hold_valid;
    assign start_ok    = (state == IDLE) && start && (word_count <= MAX_CNT);
    assign crc_en      = tx_fire && (state == PAYLOAD);
    // CRC including the byte leaving this cycle, so CRC_LO can follow without a gap.
    assign crc_after   = crc16_byte(crc, tx_data);
    assign crc_final   = tx_fire ? crc_after : crc;

    usb_crc16 u_crc (
        .clk  (clk),
        .rst  (rst),
        .init (start_ok),
        .en   (crc_en),
        .din  (tx_data),
        .crc  (crc)
    );

    // RAM read issue and the hold/shift prefetch buffers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_en     <= 1'b0;
            ram_addr   <= '0;
            next_addr  <= '0;
            rd_left    <= '0;
            rd_pending <= 1'b0;
            hold_data  <= '0;
            hold_valid <= 1'b0;
            sh_data    <= '0;
            sh_cnt     <= '0;
        end else begin
            rd_pending <= ram_en;
            ram_en     <= 1'b0;
            if (start_ok) begin
                ram_addr  <= base_addr;
                next_addr <= base_addr + ADDR_W'(1);
                ram_en    <= (word_count != '0);
                rd_left   <= (word_count == '0) ? '0 : word_count - CNT_W'(1);
            end else if (issue_rd) begin
                ram_en    <= 1'b1;
                ram_addr  <= next_addr;
                next_addr <= next_addr + ADDR_W'(1);
                rd_left   <= rd_left - CNT_W'(1);
            end

            if (pop) begin
                if (src_sh) begin
                    sh_data <= sh_data >> 8;
                    sh_cnt  <= sh_cnt - SC_W'(1);
                end else begin
                    sh_data    <= hold_data >> 8;
                    sh_cnt     <= SC_LOAD;
                    hold_valid <= 1'b0;
                end
            end else if (!src_sh && hold_valid && state == PAYLOAD) begin
                sh_data    <= hold_data;
                sh_cnt     <= SC_FULL;
                hold_valid <= 1'b0;
            end

            // Only one read is ever in flight, so the hold register is empty here.
            if (rd_pending) begin
                hold_data  <= ram_rdata;
                hold_valid <= 1'b1;
            end
        end
    end

    // Packet FSM driving the byte stream and status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pid_q       <= '0;
            has_payload <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            tx_data     <= '0;
            tx_valid    <= 1'b0;
            tx_last     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (word_count > MAX_CNT) begin
                            err <= 1'b1;
                        end else begin
                            state       <= PID;
                            busy        <= 1'b1;
                            pid_q       <= pid;
                            has_payload <= (word_count != '0);
                        end
                    end
                end
                PID: begin
                    // Hold the PID back until the first word is arriving so payload follows without a bubble.
                    if (!tx_valid) begin
                        if (!has_payload || rd_pending) begin
                            tx_data  <= {~pid_q, pid_q};
                            tx_valid <= 1'b1;
                        end
                    end else if (tx_ready) begin
                        if (has_payload) begin
                            state    <= PAYLOAD;
                            tx_data  <= next_byte;
                            tx_valid <= byte_avail;
                        end else begin
                            state    <= CRC_LO;
                            tx_data  <= ~crc[7:0];
                            tx_valid <= 1'b1;
                        end
                    end
                end
                PAYLOAD: begin
                    if (out_free) begin
                        if (byte_avail) begin
                            tx_data  <= next_byte;
                            tx_valid <= 1'b1;
                        end else if (reads_done) begin
                            state    <= CRC_LO;
                            tx_data  <= ~crc_final[7:0];
                            tx_valid <= 1'b1;
                        end else begin
                            tx_valid <= 1'b0;
                        end
                    end
                end
                CRC_LO: begin
                    if (tx_ready) begin
                        state   <= CRC_HI;
                        tx_data <= ~crc[15:8];
                        tx_last <= 1'b1;
                    end
                end
                CRC_HI: begin
                    if (tx_ready) begin
                        state    <= IDLE;
                        tx_valid <= 1'b0;
                        tx_last  <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_pkt_builder.sv
// tb/tb_usb_pkt_builder.sv - scoreboard testbench for usb_pkt_builder
module tb_usb_pkt_builder;
    import usb_pkt_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [3:0]   pid = 4'h0;
    logic [15:0]  base_addr = 16'h0;
    logic [6:0]   word_count = 7'h0;
    logic         busy, done, err, ram_en, tx_valid, tx_last;
    logic [15:0]  ram_addr;
    logic [127:0] ram_rdata = '0;
    logic [7:0]   tx_data;
    logic         tx_ready = 1'b1;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int first_cyc = 0;
    int last_cyc = 0;
    bit rdy_rand = 1'b0;

    logic [8:0]  exp_q[$];
    logic [15:0] addr_q[$];

    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h0;
    bit         prev_en = 1'b0;

    usb_pkt_builder dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pid        (pid),
        .base_addr  (base_addr),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .ram_en     (ram_en),
        .ram_addr   (ram_addr),
        .ram_rdata  (ram_rdata),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_last    (tx_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // RAM contents: byte i of word a is {a[3:0], i} ^ a[15:8]; word 0x0010 is 0F0E..0100.
    function automatic logic [127:0] pattern(input logic [15:0] a);
        logic [127:0] w;
        for (int i = 0; i < 16; i++) w[i*8 +: 8] = {a[3:0], 4'(i)} ^ a[15:8];
        return w;
    endfunction

    always @(posedge clk) if (ram_en) ram_rdata <= pattern(ram_addr);

    always begin
        @(posedge clk);
        #1;
        tx_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    function automatic logic [15:0] tb_crc(input logic [15:0] c, input logic [7:0] d);
        logic fb;
        for (int i = 0; i < 8; i++) begin
            fb = c[0] ^ d[i];
            c = {1'b0, c[15:1]};
            if (fb) c = c ^ 16'hA001;
        end
        return c;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake and watches RAM reads.
    always @(negedge clk) begin
        logic [8:0]  e;
        logic [15:0] ea;
        if (rst) begin
            prev_stall = 1'b0;
            prev_en = 1'b0;
        end else begin
            if (prev_stall) begin
                n_chk++;
                if (!tx_valid || tx_data !== prev_data) begin
                    n_fail++;
                    $display("FAIL stall_hold: valid=%0b data=%0h held data %0h", tx_valid, tx_data, prev_data);
                end
            end
            if (tx_valid && tx_ready) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_byte: got %0h expected none", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({tx_last, tx_data} !== e) begin
                        n_fail++;
                        $display("FAIL byte %0d: got last=%0b data=%0h expected last=%0b data=%0h",
                                 acc_cnt, tx_last, tx_data, e[8], e[7:0]);
                    end
                end
                if (acc_cnt == 0) first_cyc = cyc;
                last_cyc = cyc;
                acc_cnt++;
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data = tx_data;
            if (ram_en) begin
                n_chk++;
                if (addr_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_read: got addr %0h expected no read", ram_addr);
                end else begin
                    ea = addr_q.pop_front();
                    if (ram_addr !== ea) begin
                        n_fail++;
                        $display("FAIL ram_addr: got %0h expected %0h", ram_addr, ea);
                    end
                end
                n_chk++;
                if (prev_en) begin
                    n_fail++;
                    $display("FAIL read_outstanding: got back-to-back ram_en expected gap");
                end
            end
            prev_en = ram_en;
        end
    end

    task automatic build_exp(input logic [3:0] p, input logic [15:0] b, input int n);
        logic [15:0]  c;
        logic [15:0]  a;
        logic [127:0] w;
        logic [7:0]   by;
        c = 16'hFFFF;
        exp_q.push_back({1'b0, ~p, p});
        for (int k = 0; k < n; k++) begin
            a = b + 16'(k);
            addr_q.push_back(a);
            w = pattern(a);
            for (int j = 0; j < 16; j++) begin
                by = w[j*8 +: 8];
                exp_q.push_back({1'b0, by});
                c = tb_crc(c, by);
            end
        end
        exp_q.push_back({1'b0, ~c[7:0]});
        exp_q.push_back({1'b1, ~c[15:8]});
    endtask

    task automatic pulse_start(input logic [3:0] p, input logic [15:0] b, input int n);
        @(posedge clk);
        #1;
        pid = p;
        base_addr = b;
        word_count = 7'(n);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int total, input bit check_gap);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 4000 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        n_chk++;
        if (!got) begin
            n_fail++;
            $display("FAIL %s_timeout: got no done expected done within 4000 cycles", name);
        end else begin
            chk({name, "_busy_at_done"}, 32'(busy), 32'd0);
            chk({name, "_done_latency"}, 32'(cyc - last_cyc), 32'd1);
            chk({name, "_byte_count"}, 32'(acc_cnt), 32'(total));
            if (check_gap) chk({name, "_no_bubbles"}, 32'(last_cyc - first_cyc), 32'(total - 1));
            chk({name, "_bytes_left"}, 32'(exp_q.size()), 32'd0);
            chk({name, "_reads_left"}, 32'(addr_q.size()), 32'd0);
        end
        @(negedge clk);
        chk({name, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    task automatic run_pkt(input string name, input logic [3:0] p, input logic [15:0] b,
                           input int n, input bit rnd);
        rdy_rand = rnd;
        build_exp(p, b, n);
        acc_cnt = 0;
        pulse_start(p, b, n);
        wait_done(name, 3 + 16 * n, !rnd);
    endtask

    initial begin
        bit got;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_ram_en", 32'(ram_en), 32'd0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_last", 32'(tx_last), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_pkt("zlp", DATA0, 16'h0000, 0, 1'b0);
        run_pkt("one_word", DATA0, 16'h0010, 1, 1'b0);
        run_pkt("backpressure", DATA1, 16'h0040, 4, 1'b1);
        run_pkt("no_backpressure", DATA1, 16'h0040, 4, 1'b0);
        run_pkt("wrap", DATA2, 16'hFFFE, 3, 1'b0);

        // Oversized request: dropped with an err pulse and no reads.
        rdy_rand = 1'b0;
        pulse_start(DATA0, 16'h0500, 65);
        @(negedge clk);
        chk("err_pulse", 32'(err), 32'd1);
        chk("err_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("err_pulse_end", 32'(err), 32'd0);
        chk("err_stays_idle", 32'(busy), 32'd0);

        // Second start while busy, with different inputs, must not disturb the packet.
        rdy_rand = 1'b1;
        build_exp(MDATA, 16'h0200, 2);
        acc_cnt = 0;
        pulse_start(MDATA, 16'h0200, 2);
        repeat (4) @(posedge clk);
        #1;
        pid = DATA1;
        base_addr = 16'h0100;
        word_count = 7'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("start_while_busy", 35, 1'b0);

        run_pkt("max_words", DATA0, 16'h1000, 64, 1'b0);

        // Reset during payload: outputs drop at once, next packet is clean.
        rdy_rand = 1'b1;
        build_exp(DATA0, 16'h0020, 2);
        acc_cnt = 0;
        pulse_start(DATA0, 16'h0020, 2);
        got = 1'b0;
        for (int i = 0; i < 500 && !got; i++) begin
            @(negedge clk);
            if (acc_cnt >= 6) got = 1'b1;
        end
        chk("rst_reach_byte5", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_tx_valid", 32'(tx_valid), 32'd0);
        chk("midrst_ram_en", 32'(ram_en), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        exp_q.delete();
        addr_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_pkt("after_reset", DATA1, 16'h0030, 2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
